// File: rtl/vector_op_sequencer.sv
// ----------------------------------------------------------------------------
// vector_op_sequencer
//
// Breaks the multi-cycle vector ops VDOT and SMUL into a sequence of 16-bit
// lane transactions and issues them, one at a time, to a shared scalar lane
// unit over a req/ack handshake. The lane unit does all the arithmetic; this
// block only orders the transactions, collects lane results into a working
// buffer and publishes the final vector on a one-cycle done pulse.
// Opcodes other than VDOT/SMUL complete immediately with a zero result.
//
// Ports
//   clk       in   1        system clock, all state on the rising edge
//   rst_n     in   1        asynchronous active-low reset
//   start     in   1        request a new op, sampled only while idle
//   opcode    in   4        0001 = VDOT, 0010 = SMUL, anything else = no-op
//   op_1      in   VW       vector A (VDOT) / scalar in [WIDTH-1:0] (SMUL)
//   op_2      in   VW       vector B
//   busy      out  1        high whenever the sequencer is not idle
//   done      out  1        one-cycle pulse, result valid
//   result    out  VW       registered result, held until the next done
//   lane_req  out  1        lane transaction request
//   lane_op   out  1        0 = MUL, 1 = ADD
//   lane_a    out  WIDTH    lane operand a
//   lane_b    out  WIDTH    lane operand b
//   lane_ack  in   1        lane unit accepts and returns lane_res this cycle
//   lane_res  in   WIDTH    lane result, valid when lane_req & lane_ack
//
// Transaction order
//   VDOT: for each lane i (ascending) MUL(a_i, b_i) -> prod, then
//         ADD(acc, prod) -> acc. Result = {zeros, acc}.
//   SMUL: for each lane i (ascending) MUL(op_1[WIDTH-1:0], b_i) -> lane i.
//
// Every acked transaction is followed by exactly one idle GAP cycle before
// the next request; the ack of the final transaction goes straight to DONE.
// LANES must be a power of two so the lane index is a plain counter slice.
// ----------------------------------------------------------------------------
module vector_op_sequencer #(
   parameter int LANES = 16,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [3:0]             opcode,
   input  logic [LANES*WIDTH-1:0] op_1,
   input  logic [LANES*WIDTH-1:0] op_2,
   output logic                   busy,
   output logic                   done,
   output logic [LANES*WIDTH-1:0] result,
   output logic                   lane_req,
   output logic                   lane_op,
   output logic [WIDTH-1:0]       lane_a,
   output logic [WIDTH-1:0]       lane_b,
   input  logic                   lane_ack,
   input  logic [WIDTH-1:0]       lane_res
);

   localparam int VW = LANES * WIDTH;
   localparam int LW = $clog2(LANES);      // lane index width
   localparam int TW = LW + 1;             // transaction counter covers 2*LANES

   localparam logic [3:0] OPC_VDOT = 4'b0001;
   localparam logic [3:0] OPC_SMUL = 4'b0010;

   localparam logic LANE_MUL = 1'b0;
   localparam logic LANE_ADD = 1'b1;

   localparam logic [TW-1:0] LAST_VDOT = TW'(2 * LANES - 1);
   localparam logic [TW-1:0] LAST_SMUL = TW'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_GAP,
      S_DONE
   } state_t;

   typedef struct packed {
      logic             op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } lane_cmd_t;

   state_t           state;
   logic             vdot_q;      // latched op kind: 1 = VDOT, 0 = SMUL
   logic [VW-1:0]    vec_a;
   logic [VW-1:0]    vec_b;
   logic [VW-1:0]    work;        // working buffer; VDOT keeps acc in lane 0
   logic [VW-1:0]    work_next;
   logic [WIDTH-1:0] prod;        // VDOT product waiting for its ADD
   logic [TW-1:0]    txn;         // index of the current transaction

   logic             accept;      // current request is acknowledged
   logic             last_txn;
   logic [LW-1:0]    cur_lane;
   lane_cmd_t        cmd_first;
   lane_cmd_t        cmd_next;

   // -------------------------------------------------------------------------
   // Lane command for transaction t. For VDOT the even transactions are the
   // MULs of lane t/2 and the odd ones fold the pending product into acc.
   // -------------------------------------------------------------------------
   function automatic lane_cmd_t build_cmd(
      input logic             vdot,
      input logic [VW-1:0]    va,
      input logic [VW-1:0]    vb,
      input logic [TW-1:0]    t,
      input logic [WIDTH-1:0] acc,
      input logic [WIDTH-1:0] p
   );
      lane_cmd_t     c;
      logic [LW-1:0] li;
      li = vdot ? t[TW-1:1] : t[LW-1:0];
      c.op = LANE_MUL;
      c.a  = va[WIDTH*li +: WIDTH];
      c.b  = vb[WIDTH*li +: WIDTH];
      if (vdot) begin
         if (t[0]) begin
            c.op = LANE_ADD;
            c.a  = acc;
            c.b  = p;
         end
      end else begin
         c.a = va[WIDTH-1:0];   // SMUL scalar lives in element 0 of op_1
      end
      return c;
   endfunction

   assign accept   = (state == S_REQ) && lane_ack;
   assign last_txn = vdot_q ? (txn == LAST_VDOT) : (txn == LAST_SMUL);
   assign cur_lane = vdot_q ? txn[TW-1:1] : txn[LW-1:0];

   // First transaction is built straight from the ports, since the operand
   // registers are only being loaded on the same edge.
   assign cmd_first = build_cmd(opcode == OPC_VDOT, op_1, op_2, '0, '0, '0);
   assign cmd_next  = build_cmd(vdot_q, vec_a, vec_b, txn, work[WIDTH-1:0], prod);

   // -------------------------------------------------------------------------
   // Working buffer with this cycle's lane result merged in. The final result
   // is taken from here so the last transaction's value lands in result on
   // the same edge that raises done.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first so every path assigns work_next and no latch is inferred.
      work_next = work;
      if (accept) begin
         if (vdot_q) begin
            if (txn[0]) begin
               work_next[WIDTH-1:0] = lane_res;
            end
         end else begin
            work_next[WIDTH*cur_lane +: WIDTH] = lane_res;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer FSM with registered outputs.
   // -------------------------------------------------------------------------
   // NOTE: the operand and working buffers are plain flops, not a RAM, so they
   // share the async reset and every output is a clean 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         lane_req <= 1'b0;
         lane_op  <= 1'b0;
         lane_a   <= '0;
         lane_b   <= '0;
         vdot_q   <= 1'b0;
         vec_a    <= '0;
         vec_b    <= '0;
         work     <= '0;
         prod     <= '0;
         txn      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order in this block.
         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  vdot_q <= (opcode == OPC_VDOT);
                  vec_a  <= op_1;
                  vec_b  <= op_2;
                  work   <= '0;       // VDOT accumulator starts at zero
                  prod   <= '0;
                  txn    <= '0;
                  busy   <= 1'b1;
                  if (opcode == OPC_VDOT || opcode == OPC_SMUL) begin
                     state    <= S_REQ;
                     lane_req <= 1'b1;
                     lane_op  <= cmd_first.op;
                     lane_a   <= cmd_first.a;
                     lane_b   <= cmd_first.b;
                  end else begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     result <= '0;
                  end
               end
            end

            S_REQ: begin
               // Operands stay untouched here so they are stable while the
               // lane unit holds off its ack.
               if (lane_ack) begin
                  work     <= work_next;
                  lane_req <= 1'b0;
                  if (vdot_q && !txn[0]) begin
                     prod <= lane_res;
                  end
                  if (last_txn) begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     result <= work_next;
                     txn    <= '0;
                  end else begin
                     state <= S_GAP;
                     txn   <= txn + 1'b1;
                  end
               end
            end

            S_GAP: begin
               state    <= S_REQ;
               lane_req <= 1'b1;
               lane_op  <= cmd_next.op;
               lane_a   <= cmd_next.a;
               lane_b   <= cmd_next.b;
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               lane_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vector_op_sequencer
//
// Directed bench for vector_op_sequencer. A behavioural lane unit (mod 2^16
// MUL/ADD) answers requests with a programmable ack delay; expected lane
// commands and results are computed here from the input vectors.
// Cycle numbering: start is sampled at edge 0, cycle n is observed on the
// falling edge after edge n-1.
// ----------------------------------------------------------------------------
module tb_vector_op_sequencer;

   localparam int LANES = 16;
   localparam int WIDTH = 16;
   localparam int VW    = LANES * WIDTH;

   localparam logic [3:0] OPC_NOP  = 4'b0000;
   localparam logic [3:0] OPC_VDOT = 4'b0001;
   localparam logic [3:0] OPC_SMUL = 4'b0010;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [3:0]       opcode;
   logic [VW-1:0]    op_1;
   logic [VW-1:0]    op_2;
   logic             busy;
   logic             done;
   logic [VW-1:0]    result;
   logic             lane_req;
   logic             lane_op;
   logic [WIDTH-1:0] lane_a;
   logic [WIDTH-1:0] lane_b;
   logic             lane_ack;
   logic [WIDTH-1:0] lane_res;

   int n_checks = 0;
   int n_errors = 0;

   vector_op_sequencer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .opcode   (opcode),
      .op_1     (op_1),
      .op_2     (op_2),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .lane_req (lane_req),
      .lane_op  (lane_op),
      .lane_a   (lane_a),
      .lane_b   (lane_b),
      .lane_ack (lane_ack),
      .lane_res (lane_res)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".busy"},     VW'(busy),     '0);
      check({tag, ".done"},     VW'(done),     '0);
      check({tag, ".lane_req"}, VW'(lane_req), '0);
      check({tag, ".lane_cmd"}, VW'({lane_op, lane_a, lane_b}), '0);
      check({tag, ".result"},   result,        '0);
   endtask

   // -------------------------------------------------------------------------
   // Run one op. The lane unit model and the protocol monitor live in the
   // same per-cycle loop: every falling edge observes the DUT and drives the
   // ack/result that the next rising edge samples.
   //   exp_cyc < 0 : done cycle not checked (random ack delays)
   //   stray       : assert lane_ack in every cycle lane_req is low
   //   poke        : pulse start mid-op and in the DONE cycle
   // -------------------------------------------------------------------------
   task automatic run_op(input string name, input logic [3:0] opc,
                         input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input int max_delay, input logic [VW-1:0] exp_res,
                         input int exp_cyc, input int exp_nreq,
                         input bit stray, input bit poke);
      int               cyc, nreq, wait_n, last_ack, k, li;
      bit               prev_req, prev_acked, got_done, vdot;
      logic             h_op, e_op;
      logic [WIDTH-1:0] h_a, h_b, e_a, e_b, m_acc, m_prod;

      vdot = (opc == OPC_VDOT);
      cyc = 0; nreq = 0; wait_n = 0; last_ack = 0;
      prev_req = 1'b0; prev_acked = 1'b0; got_done = 1'b0;
      h_op = 1'b0; h_a = '0; h_b = '0; m_acc = '0; m_prod = '0;

      @(negedge clk);
      start  = 1'b1;
      opcode = opc;
      op_1   = a;
      op_2   = b;
      @(posedge clk);   // edge 0

      while (!got_done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (poke && cyc == 5) begin start = 1'b1; opcode = OPC_NOP; end
         if (poke && cyc == 6) begin start = 1'b0; opcode = opc; end

         if (lane_req) begin
            if (!prev_req || prev_acked) begin
               // New transaction: check order, operands and spacing.
               nreq++;
               k  = nreq - 1;
               li = (vdot ? k / 2 : k) % LANES;
               e_op = 1'b0;
               e_a  = vdot ? a[WIDTH*li +: WIDTH] : a[WIDTH-1:0];
               e_b  = b[WIDTH*li +: WIDTH];
               if (vdot && k[0]) begin
                  e_op  = 1'b1;
                  e_a   = m_acc;
                  e_b   = m_prod;
                  m_acc = m_acc + m_prod;
               end else if (vdot) begin
                  m_prod = e_a * e_b;
               end
               check($sformatf("%s.cmd%0d", name, k), VW'({lane_op, lane_a, lane_b}),
                     VW'({e_op, e_a, e_b}));
               if (nreq == 1) check({name, ".first_req_cycle"}, VW'(cyc), VW'(1));
               else           check($sformatf("%s.gap%0d", name, k), VW'(cyc - last_ack), VW'(2));
               h_op = lane_op; h_a = lane_a; h_b = lane_b;
               wait_n = $urandom_range(max_delay, 0);
            end else begin
               check({name, ".held_cmd"}, VW'({lane_op, lane_a, lane_b}), VW'({h_op, h_a, h_b}));
            end
            if (wait_n == 0) begin
               lane_ack   = 1'b1;
               lane_res   = lane_op ? lane_a + lane_b : lane_a * lane_b;
               last_ack   = cyc;
               prev_acked = 1'b1;
            end else begin
               lane_ack   = 1'b0;
               lane_res   = 16'h5a5a;
               wait_n--;
               prev_acked = 1'b0;
            end
         end else begin
            lane_ack   = stray;
            lane_res   = 16'hbeef;
            prev_acked = 1'b0;
         end
         prev_req = lane_req;

         if (done) begin
            got_done = 1'b1;
            check({name, ".result"}, result, exp_res);
            check({name, ".busy_at_done"}, VW'(busy), VW'(1));
            check({name, ".nreq"}, VW'(nreq), VW'(exp_nreq));
            if (exp_cyc >= 0) check({name, ".done_cycle"}, VW'(cyc), VW'(exp_cyc));
         end
      end
      lane_ack = 1'b0;
      if (!got_done) check({name, ".done_timeout"}, VW'(0), VW'(1));

      if (poke) begin start = 1'b1; opcode = OPC_VDOT; end
      @(negedge clk);
      start = 1'b0;
      check({name, ".after_done"}, VW'({done, busy}), '0);
      if (poke) begin
         repeat (6) begin
            @(negedge clk);
            check({name, ".ignored_start"}, VW'({done, busy, lane_req}), '0);
         end
      end
   endtask

   logic [VW-1:0] va_ones, vb_inc, vb_idx, va_scalar, exp_dot, exp_smul;
   logic [VW-1:0] smul_prev;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      opcode   = '0;
      op_1     = '0;
      op_2     = '0;
      lane_ack = 1'b0;
      lane_res = '0;

      va_ones = '0; vb_inc = '0; vb_idx = '0; exp_smul = '0;
      for (int i = 0; i < LANES; i++) begin
         va_ones[WIDTH*i +: WIDTH]  = 16'd1;
         vb_inc[WIDTH*i +: WIDTH]   = WIDTH'(i + 1);
         vb_idx[WIDTH*i +: WIDTH]   = WIDTH'(i);
         exp_smul[WIDTH*i +: WIDTH] = WIDTH'(3 * i);
      end
      va_scalar = VW'(16'd3);
      exp_dot   = VW'(16'd136);   // 1+2+...+16

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic VDOT and SMUL, ack in the same cycle as the request
      run_op("vdot", OPC_VDOT, va_ones, vb_inc, 0, exp_dot, 64, 32, 1'b0, 1'b0);
      run_op("smul", OPC_SMUL, va_scalar, vb_idx, 0, exp_smul, 32, 16, 1'b0, 1'b0);

      // Random ack delays 0..5
      run_op("vdot_slow", OPC_VDOT, va_ones, vb_inc, 5, exp_dot, -1, 32, 1'b0, 1'b0);
      run_op("smul_slow", OPC_SMUL, va_scalar, vb_idx, 5, exp_smul, -1, 16, 1'b0, 1'b0);

      // No-op replaces the previous SMUL result with 0
      smul_prev = result;
      check("nop.prev_result", smul_prev, exp_smul);
      run_op("nop", OPC_NOP, va_ones, vb_inc, 0, '0, 1, 0, 1'b0, 1'b0);

      // Start pulses while busy / in DONE, plus stray acks while req is low
      run_op("smul_poke", OPC_SMUL, va_scalar, vb_idx, 2, exp_smul, -1, 16, 1'b1, 1'b1);

      // Reset in the middle of a VDOT
      @(negedge clk);
      start  = 1'b1;
      opcode = OPC_VDOT;
      op_1   = va_ones;
      op_2   = vb_inc;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         lane_ack = lane_req;
         lane_res = lane_op ? lane_a + lane_b : lane_a * lane_b;
      end
      check("rst_mid.busy_before", VW'(busy), VW'(1));
      #1 rst_n = 1'b0;
      lane_ack = 1'b0;
      #1 check_outputs_zero("rst_mid");
      repeat (3) begin
         @(negedge clk);
         check("rst_mid.no_done", VW'({done, busy, lane_req}), '0);
      end
      rst_n = 1'b1;
      run_op("vdot_after_rst", OPC_VDOT, va_ones, vb_inc, 0, exp_dot, 64, 32, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
